// File: rtl/bit_serial_adder.sv
`default_nettype none
// ============================================================================
// Module   : bit_serial_adder
// Purpose  : LSB-first serial adder built around one full-adder bit slice
//            and one carry flip-flop. Operands are captured on an accepted
//            start. One bit pair is processed per clock. Sum bits shift into
//            the result register from the top.
//            Latency is WIDTH+1 cycles from the accepted start to done.
// Macro    : SERIAL_ADDER_SUB_EN - when defined, adds the 'sub' input. With
//            sub=1 the block computes a - b. cout=1 then means no borrow.
// Ports    : clk   - system clock, rising edge
//            rst   - synchronous active-high reset
//            start - request pulse, sampled only when not busy
//            sub   - (SERIAL_ADDER_SUB_EN only) subtract select
//            a, b  - WIDTH-bit operands, captured on accepted start
//            cin   - carry-in, captured on accepted start
//            busy  - high while bits are being processed
//            done  - one-cycle pulse; sum/cout valid
//            sum   - (a + b + cin) mod 2^WIDTH
//            cout  - carry out of bit WIDTH-1
// Revision : 1.0 - initial release
// ============================================================================
module bit_serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             sub,
`endif
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int               CNT_W    = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] op_a_q, op_a_d;
  logic [WIDTH-1:0] op_b_q, op_b_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             accept;
  logic             fa_s;
  logic             fa_c;
  logic [WIDTH-1:0] b_load;
  logic             carry_load;

  // A start is honoured in DONE as well as IDLE, so back-to-back requests
  // lose no cycle.
  assign accept = start && (state_q != SHIFT);

  // Subtraction is a + ~b + 1. The +1 comes in through the carry flop.
`ifdef SERIAL_ADDER_SUB_EN
  assign b_load     = sub ? ~b : b;
  assign carry_load = sub ? 1'b1 : cin;
`else
  assign b_load     = b;
  assign carry_load = cin;
`endif

  // Full-adder bit slice
  always_comb begin
    fa_s = op_a_q[0] ^ op_b_q[0] ^ carry_q;
    fa_c = (op_a_q[0] & op_b_q[0]) | (op_a_q[0] & carry_q) | (op_b_q[0] & carry_q);
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = SHIFT;
      SHIFT:   if (cnt_q == CNT_LAST) state_d = DONE;
      DONE:    state_d = start ? SHIFT : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    busy = (state_q == SHIFT);
    done = (state_q == DONE);
    sum  = sum_q;
    cout = carry_q;
  end

  // Datapath next values
  always_comb begin
    op_a_d  = op_a_q;
    op_b_d  = op_b_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    if (accept) begin
      op_a_d  = a;
      op_b_d  = b_load;
      carry_d = carry_load;
      cnt_d   = '0;
    end else if (state_q == SHIFT) begin
      op_a_d  = op_a_q >> 1;
      op_b_d  = op_b_q >> 1;
      sum_d   = {fa_s, sum_q[WIDTH-1:1]};
      carry_d = fa_c;
      cnt_d   = cnt_q + 1'b1;
    end
  end

  // Datapath registers. Sum and carry are not touched outside SHIFT,
  // so the result holds until the next accepted start.
  always_ff @(posedge clk) begin
    if (rst) begin
      op_a_q  <= '0;
      op_b_q  <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      op_a_q  <= op_a_d;
      op_b_q  <= op_b_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule
`default_nettype wire

// File: doc/bit_serial_adder.md
Name: bit_serial_adder

Overview:
- Sequential LSB-first serial adder wrapped around a single full-adder bit slice: one combinational A/B/Ci -> Co/So cell plus one carry flip-flop.
- Takes two WIDTH-bit operands through a start/done handshake.
- Feeds one operand bit pair per clock into the slice, registers the carry, and shifts the sum bits into a result register.
- Sits directly upstream of the full-adder cell, sequencing its inputs and capturing its outputs; used wherever adder area matters more than latency.

Parameters:
- WIDTH, 8, operand and sum width in bits (legal range 2..32).

Ports:
- clk  input  1  single system clock, all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request pulse; sampled only when not busy.
- a  input  WIDTH  operand A, captured on the accepted start.
- b  input  WIDTH  operand B, captured on the accepted start.
- cin  input  1  carry-in, captured on the accepted start.
- busy  output  1  high while bits are being processed.
- done  output  1  one-cycle pulse: sum/cout valid.
- sum  output  WIDTH  result (a + b + cin) mod 2^WIDTH.
- cout  output  1  carry out of bit WIDTH-1.

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high. rst=1 at a rising edge forces state=IDLE, busy=0, done=0, sum=0, cout=0, carry FF=0, bit counter=0, operand registers=0. rst overrides start.
- FSM states: IDLE, SHIFT, DONE.
  - IDLE: start=1 captures a, b, cin into op_a, op_b, carry FF; counter=0; next state SHIFT.
  - SHIFT: each edge computes s = op_a[0]^op_b[0]^carry and c = majority(op_a[0], op_b[0], carry) through the bit slice. Then carry<=c, op_a/op_b shift right by 1, and the sum register shifts right with s entering at bit WIDTH-1. Counter increments. On the edge where counter==WIDTH-1, next state is DONE.
  - DONE: lasts one cycle, then returns to IDLE. A start in DONE is accepted exactly as in IDLE and goes straight to SHIFT.
- Outputs:
  - busy=1 exactly while state==SHIFT.
  - done=1 exactly while state==DONE.
  - sum and cout = final carry FF value are valid from the DONE cycle and held unchanged until the next accepted start.
- Latency: start sampled at edge k; done high in the cycle following edge k+WIDTH; WIDTH+1 cycles total. Throughput: one add per WIDTH+1 cycles.
- start while busy=1 is ignored; operands are not re-captured.
- a, b and cin may change freely after the accepted start.
- Arithmetic is unsigned modular; no saturation.
- Reset mid-SHIFT aborts the operation: done never pulses and sum reads 0.
- Counter width is clog2(WIDTH)+1; no wrap occurs because the FSM leaves SHIFT at WIDTH-1.

Optional Feature:
- Macro: SERIAL_ADDER_SUB_EN.
- Defined:
  - Adds input port sub (1 bit), captured on the accepted start.
  - When sub=1, op_b is loaded as ~b and the carry FF is loaded with 1 (cin ignored), giving sum = a - b mod 2^WIDTH.
  - cout=1 means no borrow (a>=b unsigned).
  - When sub=0, behaviour is identical to the undefined build.
- Undefined: no sub port; addition only.

Test Plan (WIDTH=8):
- Reset then idle: rst=1 for 2 cycles -> busy=0, done=0, sum=0x00, cout=0; no activity without start.
- Basic add: a=0x5A, b=0x33, cin=0, start pulse -> busy high 8 cycles; done pulses on the 9th cycle with sum=0x8D, cout=0; values held afterwards.
- Carry ripple and full range:
  - 0xFF+0x01, cin=0 -> sum=0x00, cout=1.
  - 0xFF+0xFF, cin=1 -> sum=0xFF, cout=1.
- Handshake:
  - start held high continuously with a=0x01, b=0x02 -> starts ignored while busy; ops complete back-to-back; done pulses every 9 cycles with sum=0x03.
  - Changing a/b mid-op has no effect on the result.
- Reset mid-operation: a=0x80, b=0x80, start, rst asserted at cycle 4 -> busy=0 next cycle, no done pulse, sum=0, cout=0. A following add of 0x10+0x20 gives 0x30.
- SERIAL_ADDER_SUB_EN:
  - sub=1, a=0x10, b=0x01 -> sum=0x0F, cout=1.
  - sub=1, a=0x01, b=0x02 -> sum=0xFF, cout=0.
